// File: rtl/hv_sched_pkg.sv
// Shared constants and state encoding for the HV ramp scheduler and its DAC frame partner.
package hv_sched_pkg;

    localparam int NCH = 32;
    localparam int DW  = 10;

    // Minimum WAIT length: DAC frame through bitcnt 180 plus LOAD release at 196.
    localparam int HV_DAC_FRAME_MIN = 197;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_WAIT    = 2'd3
    } hv_state_e;

endpackage

// File: rtl/hv_ramp_step.sv
// Single-channel rate-limited step: moves cur toward tgt by at most step codes.
module hv_ramp_step #(
    parameter int DW = hv_sched_pkg::DW
) (
    input  logic [DW-1:0] tgt_i,
    input  logic [DW-1:0] cur_i,
    input  logic [DW-1:0] step_i,
    input  logic          ramp_en_i,
    output logic [DW-1:0] next_o,
    output logic          changed_o,
    output logic          remaining_o
);

    logic signed [DW:0] diff;
    logic signed [DW:0] mag;

    always_comb begin
        diff        = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
        mag         = diff[DW] ? -diff : diff;
        next_o      = cur_i;
        changed_o   = 1'b0;
        remaining_o = 1'b0;
        if (diff != '0) begin
            changed_o = 1'b1;
            if (!ramp_en_i || (mag <= $signed({1'b0, step_i}))) begin
                next_o = tgt_i;
            end else begin
                // |diff| > step here, so the step cannot cross the target or leave 0..2^DW-1
                remaining_o = 1'b1;
                next_o      = diff[DW] ? (cur_i - step_i) : (cur_i + step_i);
            end
        end
    end

endmodule

// File: rtl/hv_ramp_sched.sv
// HV target store and rate limiter feeding dac_ctrl_fsm; applied codes only move
// during COMPUTE so they are frozen for the whole DAC frame that follows hv_update.
module hv_ramp_sched #(
    parameter int NCH      = hv_sched_pkg::NCH,
    parameter int DW       = hv_sched_pkg::DW,
    parameter int STEP     = 8,
    parameter int BUSY_CYC = 200
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [4:0]        wr_ch,
    input  logic [DW-1:0]     wr_val,
    input  logic              ramp_en,
    input  logic              kill,
    output logic [NCH*DW-1:0] hv_reg_dout,
    output logic              hv_update,
    output logic              busy,
    output logic              settled,
    output logic [15:0]       upd_cnt
);

    import hv_sched_pkg::*;

    localparam logic [DW-1:0] STEP_C   = DW'(STEP);
    localparam logic [7:0]    WAIT_END = 8'(BUSY_CYC - 1);
    localparam logic [4:0]    LAST_CH  = 5'(NCH - 1);

    hv_state_e       state_q, state_d;
    logic [DW-1:0]   tgt_q [NCH];
    logic [DW-1:0]   cur_q [NCH];
    logic            pend_q, pend_d;
    logic            chg_q, chg_d;
    logic            more_q, more_d;
    logic [4:0]      ch_cnt_q, ch_cnt_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            hv_update_q;
    logic [15:0]     upd_cnt_q;
    logic            cur_we;

    logic [DW-1:0]   step_next;
    logic            step_chg;
    logic            step_rem;

    hv_ramp_step #(.DW(DW)) u_step (
        .tgt_i       (tgt_q[ch_cnt_q]),
        .cur_i       (cur_q[ch_cnt_q]),
        .step_i      (STEP_C),
        .ramp_en_i   (ramp_en),
        .next_o      (step_next),
        .changed_o   (step_chg),
        .remaining_o (step_rem)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        chg_d      = chg_q;
        more_d     = more_q;
        ch_cnt_d   = ch_cnt_q;
        wait_cnt_d = wait_cnt_q;
        cur_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d  = ST_COMPUTE;
                    pend_d   = 1'b0;
                    chg_d    = 1'b0;
                    more_d   = 1'b0;
                    ch_cnt_d = '0;
                end
            end
            ST_COMPUTE: begin
                cur_we   = 1'b1;
                chg_d    = chg_q | step_chg;
                more_d   = more_q | step_rem;
                ch_cnt_d = ch_cnt_q + 5'd1;
                if (ch_cnt_q == LAST_CH) begin
                    pend_d  = pend_q | more_d;
                    state_d = chg_d ? ST_ISSUE : ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_q == WAIT_END) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A same-cycle write must never be lost to the IDLE clear
        if (kill || wr_en) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            chg_q       <= 1'b0;
            more_q      <= 1'b0;
            ch_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            hv_update_q <= 1'b0;
            upd_cnt_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                tgt_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            chg_q       <= chg_d;
            more_q      <= more_d;
            ch_cnt_q    <= ch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            hv_update_q <= (state_d == ST_ISSUE);
            if (state_q == ST_ISSUE) begin
                upd_cnt_q <= upd_cnt_q + 16'd1;
            end
            if (kill) begin
                for (int i = 0; i < NCH; i++) begin
                    tgt_q[i] <= '0;
                end
            end else if (wr_en) begin
                tgt_q[wr_ch] <= wr_val;
            end
            if (cur_we) begin
                cur_q[ch_cnt_q] <= step_next;
            end
        end
    end

    always_comb begin
        hv_reg_dout = '0;
        for (int i = 0; i < NCH; i++) begin
            hv_reg_dout[i*DW +: DW] = cur_q[i];
        end
    end

    assign hv_update = hv_update_q;
    assign upd_cnt   = upd_cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign settled   = (state_q == ST_IDLE) && !pend_q;

endmodule
